// File: rtl/i2c_txn_scheduler_if.sv
// Request/response bus between local requesters, the scheduler and the shared I2C controller.
// The scheduler attaches through the slave modport; requesters and controller sit on the master side.
interface i2c_txn_scheduler_if #(
    parameter int NUM_REQ           = 3,
    parameter int BYTES_SEND_LOG    = 2,
    parameter int BYTES_RECEIVE_LOG = 2
);
    localparam int BITS_SEND_MAX = ((2 ** BYTES_SEND_LOG) - 1) << 3;
    localparam int BITS_RECV_MAX = ((2 ** BYTES_RECEIVE_LOG) - 1) << 3;

    logic [NUM_REQ-1:0]                   req;
    logic [NUM_REQ*8-1:0]                 req_addr;
    logic [NUM_REQ*BITS_SEND_MAX-1:0]     req_data;
    logic [NUM_REQ*BYTES_SEND_LOG-1:0]    req_nsend;
    logic [NUM_REQ*BYTES_RECEIVE_LOG-1:0] req_nrecv;
    logic [NUM_REQ-1:0]                   grant;
    logic [NUM_REQ-1:0]                   done;
    logic [1:0]                           status;
    logic [BITS_RECV_MAX-1:0]             rsp_data;

    logic                                 ctl_start;
    logic [7:0]                           ctl_addr;
    logic [BITS_SEND_MAX-1:0]             ctl_data_send;
    logic [BYTES_SEND_LOG-1:0]            ctl_num_bytes_send;
    logic [BYTES_RECEIVE_LOG-1:0]         ctl_num_bytes_receive;
    logic                                 ctl_busy;
    logic                                 ctl_nack;
    logic                                 ctl_arb_lost;
    logic [BITS_RECV_MAX-1:0]             ctl_data_received;

    modport slave (
        input  req, req_addr, req_data, req_nsend, req_nrecv,
        input  ctl_busy, ctl_nack, ctl_arb_lost, ctl_data_received,
        output grant, done, status, rsp_data,
        output ctl_start, ctl_addr, ctl_data_send, ctl_num_bytes_send, ctl_num_bytes_receive
    );

    modport master (
        output req, req_addr, req_data, req_nsend, req_nrecv,
        output ctl_busy, ctl_nack, ctl_arb_lost, ctl_data_received,
        input  grant, done, status, rsp_data,
        input  ctl_start, ctl_addr, ctl_data_send, ctl_num_bytes_send, ctl_num_bytes_receive
    );
endinterface

// File: rtl/i2c_txn_scheduler.sv
// Round-robin scheduler sharing one I2C controller: latches the winner's transaction, pulses
// ctl_start, watches busy for completion/timeout, retries on arbitration loss, returns status.
module i2c_txn_scheduler #(
    parameter int NUM_REQ           = 3,
    parameter int BYTES_SEND_LOG    = 2,
    parameter int BYTES_RECEIVE_LOG = 2,
    parameter int BITS_SEND_MAX     = ((2 ** BYTES_SEND_LOG) - 1) << 3,
    parameter int BITS_RECV_MAX     = ((2 ** BYTES_RECEIVE_LOG) - 1) << 3,
    parameter int START_HOLD        = 12,
    parameter int BUSY_TIMEOUT      = 1024,
    parameter int MAX_RETRY         = 3,
    parameter int RETRY_GAP         = 125
) (
    input  logic               clk,
    input  logic               rst,
    i2c_txn_scheduler_if.slave bus
);
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_A   = (BUSY_TIMEOUT > START_HOLD) ? BUSY_TIMEOUT : START_HOLD;
    localparam int CNT_TOP = (CNT_A > RETRY_GAP) ? CNT_A : RETRY_GAP;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] STAT_OK      = 2'b00;
    localparam logic [1:0] STAT_NACK    = 2'b01;
    localparam logic [1:0] STAT_ARB     = 2'b10;
    localparam logic [1:0] STAT_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_BUSY,
        ST_RUN,
        ST_GAP,
        ST_RESP
    } state_t;

    state_t                         state_q,  state_d;
    logic [CNT_W-1:0]               cnt_q,    cnt_d;
    logic [IDX_W-1:0]               rr_q,     rr_d;
    logic [RTY_W-1:0]               retry_q,  retry_d;
    logic                           nack_q,   nack_d;
    logic                           arb_q,    arb_d;
    logic [NUM_REQ-1:0]             grant_q,  grant_d;
    logic [NUM_REQ-1:0]             done_q,   done_d;
    logic [1:0]                     status_q, status_d;
    logic [BITS_RECV_MAX-1:0]       rsp_q,    rsp_d;
    logic                           start_q,  start_d;
    logic [7:0]                     addr_q,   addr_d;
    logic [BITS_SEND_MAX-1:0]       data_q,   data_d;
    logic [BYTES_SEND_LOG-1:0]      nsend_q,  nsend_d;
    logic [BYTES_RECEIVE_LOG-1:0]   nrecv_q,  nrecv_d;

    logic [7:0]                     addr_arr  [NUM_REQ];
    logic [BITS_SEND_MAX-1:0]       data_arr  [NUM_REQ];
    logic [BYTES_SEND_LOG-1:0]      nsend_arr [NUM_REQ];
    logic [BYTES_RECEIVE_LOG-1:0]   nrecv_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = bus.req_addr[gi*8 +: 8];
        assign data_arr[gi]  = bus.req_data[gi*BITS_SEND_MAX +: BITS_SEND_MAX];
        assign nsend_arr[gi] = bus.req_nsend[gi*BYTES_SEND_LOG +: BYTES_SEND_LOG];
        assign nrecv_arr[gi] = bus.req_nrecv[gi*BYTES_RECEIVE_LOG +: BYTES_RECEIVE_LOG];
    end

    // First requesting index at or after rr_q, scanning with wrap-around.
    logic             found;
    logic [IDX_W-1:0] winner;
    logic [IDX_W:0]   sum;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_q} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            if (!found && bus.req[sum[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = sum[IDX_W-1:0];
            end
        end
    end

    logic arb_now;
    logic nack_now;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        retry_d  = retry_q;
        nack_d   = nack_q;
        arb_d    = arb_q;
        grant_d  = grant_q;
        done_d   = '0;
        status_d = status_q;
        rsp_d    = rsp_q;
        start_d  = start_q;
        addr_d   = addr_q;
        data_d   = data_q;
        nsend_d  = nsend_q;
        nrecv_d  = nrecv_q;
        arb_now  = arb_q | bus.ctl_arb_lost;
        nack_now = nack_q | bus.ctl_nack;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    rr_d            = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                    addr_d          = addr_arr[winner];
                    data_d          = data_arr[winner];
                    nsend_d         = nsend_arr[winner];
                    nrecv_d         = nrecv_arr[winner];
                    start_d         = 1'b1;
                    cnt_d           = '0;
                    retry_d         = '0;
                    nack_d          = 1'b0;
                    arb_d           = 1'b0;
                    state_d         = ST_START;
                end
            end
            // cnt keeps running into WAIT_BUSY so the timeout is measured from the start rise.
            ST_START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(START_HOLD - 1)) begin
                    start_d = 1'b0;
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (bus.ctl_busy) begin
                    state_d = ST_RUN;
                end else if (cnt_q >= CNT_W'(BUSY_TIMEOUT - 1)) begin
                    status_d = STAT_TIMEOUT;
                    rsp_d    = '0;
                    done_d   = grant_q;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                arb_d  = arb_now;
                nack_d = nack_now;
                if (!bus.ctl_busy) begin
                    if (arb_now && (retry_q < RTY_W'(MAX_RETRY))) begin
                        retry_d = retry_q + 1'b1;
                        cnt_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        status_d = arb_now ? STAT_ARB : (nack_now ? STAT_NACK : STAT_OK);
                        rsp_d    = addr_q[0] ? bus.ctl_data_received : '0;
                        done_d   = grant_q;
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_GAP: begin
                nack_d = 1'b0;
                arb_d  = 1'b0;
                if (cnt_q == CNT_W'(RETRY_GAP - 1)) begin
                    cnt_d   = '0;
                    start_d = 1'b1;
                    state_d = ST_START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                start_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rr_q     <= '0;
            retry_q  <= '0;
            nack_q   <= 1'b0;
            arb_q    <= 1'b0;
            grant_q  <= '0;
            done_q   <= '0;
            status_q <= '0;
            rsp_q    <= '0;
            start_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            nsend_q  <= '0;
            nrecv_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            retry_q  <= retry_d;
            nack_q   <= nack_d;
            arb_q    <= arb_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            status_q <= status_d;
            rsp_q    <= rsp_d;
            start_q  <= start_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            nsend_q  <= nsend_d;
            nrecv_q  <= nrecv_d;
        end
    end

    assign bus.grant                 = grant_q;
    assign bus.done                  = done_q;
    assign bus.status                = status_q;
    assign bus.rsp_data              = rsp_q;
    assign bus.ctl_start             = start_q;
    assign bus.ctl_addr              = addr_q;
    assign bus.ctl_data_send         = data_q;
    assign bus.ctl_num_bytes_send    = nsend_q;
    assign bus.ctl_num_bytes_receive = nrecv_q;
endmodule
